ram_rd_streamer: RTL and testbench

//  Read-side counterpart of the RAM fill sequencer: sweeps a contiguous address range of the

---
 rtl/ram_rd_streamer_pkg.sv | 15 +
 rtl/ram_rd_skid.sv | 57 +++++
 rtl/ram_rd_streamer.sv | 130 +++++++++++++
 tb/tb_ram_rd_streamer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_streamer_pkg.sv
// Shared RAM definitions: default geometry and sequencer state encoding
// (common to the fill and read sequencers).
package ram_rd_streamer_pkg;

  localparam int unsigned RAM_ADDR_W = 8;
  localparam int unsigned RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry skid FIFO between the RAM read port and the output stream.
// When empty, an arriving word is presented directly so it can leave in its capture cycle.
module ram_rd_skid #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         empty;
  logic         push;
  logic         pop;

  assign empty     = (count == 2'd0);
  assign out_valid = !empty || in_valid;
  assign pop       = !empty && out_ready;
  // A word that bypasses an empty FIFO and is accepted at once is never stored.
  assign push      = in_valid && !(empty && out_ready);

  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = mem[rd_ptr];
    end else if (in_valid) begin
      out_data = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/ram_rd_streamer.sv
// Sweeps an address range of the 1-cycle-latency RAM, streams the words over
// valid/ready and counts words that differ from the data==addr fill pattern.
module ram_rd_streamer
  import ram_rd_streamer_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned ERR_W  = 9
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              chk_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err
);

  seq_state_e        state;
  logic [ADDR_W:0]   remain;
  logic              inflight;
  logic              inflight_last;
  logic [ADDR_W-1:0] inflight_addr;
  logic [1:0]        skid_count;
  logic [DATA_W:0]   skid_out;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;
  logic              last_xfer;

  // Never more than two words owed downstream, so the skid FIFO cannot overflow.
  assign rd_en     = (state == ST_READ) &&
                     (({1'b0, skid_count} + {2'b00, inflight}) < 3'd2);
  assign exp_data  = DATA_W'(inflight_addr);
  assign mismatch  = inflight && chk_en && (rdata != exp_data);
  assign dout      = skid_out[DATA_W-1:0];
  assign dout_last = skid_out[DATA_W];
  assign last_xfer = dout_valid && dout_ready && dout_last;

  ram_rd_skid #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .in_valid  (inflight),
    .in_data   ({inflight_last, rdata}),
    .out_ready (dout_ready),
    .out_valid (dout_valid),
    .out_data  (skid_out),
    .count     (skid_count)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      addr          <= '0;
      remain        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_addr <= '0;
      err_cnt       <= '0;
      first_err     <= '0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && (remain == (ADDR_W+1)'(1));
      inflight_addr <= addr;

      if (mismatch) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
        if (err_cnt == '0) begin
          first_err <= inflight_addr;
        end
      end

      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr      <= base_addr;
            remain    <= len;
            err_cnt   <= '0;
            first_err <= '0;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (rd_en) begin
            addr   <= addr + ADDR_W'(1);
            remain <= remain - (ADDR_W+1)'(1);
            if (remain == (ADDR_W+1)'(1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_xfer) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Bench for ram_rd_streamer: behavioural RAM, per-sweep expected-word queue and
// error tally computed from the RAM contents.
module tb_ram_rd_streamer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int EW = 9;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          chk_en = 1'b0;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;
  logic          busy;
  logic          done;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] ram [256];

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (rd_en) rdata <= ram[addr];
  end

  ram_rd_streamer #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .ERR_W  (EW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .chk_en     (chk_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .rdata      (rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .first_err  (first_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
  endtask

  // mode: 0 ready=1, 1 ready toggles 1010.., 2 random ready, 3 ready drops at word 100 (returns there)
  task automatic sweep(input int base, input int n, input logic ce, input int mode, input bit restart);
    int unsigned exp_d[$];
    int exp_err = 0;
    int exp_first = 0;
    int c = 0;
    int issued = 0;
    int xfer = 0;
    int last_c = 0;
    int budget = 6 * n + 20;
    bit held = 0;
    bit fin = 0;
    logic [DW-1:0] h_d = '0;
    logic h_l = 1'b0;

    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % 256;
      exp_d.push_back(int'(ram[a]));
      if (ce && int'(ram[a]) != a) begin
        if (exp_err == 0) exp_first = a;
        if (exp_err < 511) exp_err++;
      end
    end

    start = 1'b1;
    base_addr = 8'(base);
    len = 9'(n);
    chk_en = ce;
    while (!fin && c < budget) begin
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = (c % 2 == 0);
        2:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = (xfer < 100);
      endcase
      if (restart && c == 20) begin
        start = 1'b1;
        base_addr = 8'd7;
        len = 9'd3;
      end
      @(negedge sys_clk);
      if (c == 1) chk("busy_on", busy, 1);
      if (rd_en) begin
        chk("rd_addr", addr, (base + issued) % 256);
        chk("issue_rule", (issued - xfer) < 2, 1);
        chk("rd_in_range", issued < n, 1);
        issued++;
      end
      if (held) chk("hold", {dout_valid, dout_last, dout}, {1'b1, h_l, h_d});
      held = 0;
      if (dout_valid) begin
        if (mode == 3 && xfer == 100) begin
          chk("word100", dout, exp_d[100]);
          return;
        end
        if (dout_ready) begin
          chk("word_in_range", xfer < n, 1);
          chk("dout", dout, (xfer < n) ? exp_d[xfer] : 32'hFFFF);
          chk("last", dout_last, xfer == n - 1);
          if (mode == 0) chk("tput", c, xfer + 2);
          xfer++;
          last_c = c;
        end else begin
          held = 1;
          h_d = dout;
          h_l = dout_last;
        end
      end
      if (done) begin
        chk("done_time", c, (n == 0) ? 1 : last_c + 1);
        fin = 1;
      end
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      c++;
    end
    chk("finished", fin, 1);
    chk("words", xfer, n);
    chk("err_cnt", err_cnt, exp_err);
    chk("first_err", first_err, exp_first);
    @(negedge sys_clk);
    chk("idle_after", {busy, done}, 0);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    fill_identity();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_ctl", {rd_en, dout_valid, dout_last, busy, done}, 0);
    chk("rst_data", {addr, dout, first_err}, 0);
    chk("rst_err", err_cnt, 0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    sweep(0, 256, 1'b1, 0, 1'b0);
    sweep(250, 10, 1'b1, 1, 1'b0);

    ram[8'h20] = 8'h00;
    sweep(0, 256, 1'b1, 0, 1'b0);
    sweep(0, 256, 1'b0, 0, 1'b0);
    fill_identity();

    sweep(0, 0, 1'b1, 0, 1'b0);

    // reset while word 100 is held, with a start in the same cycle
    sweep(0, 256, 1'b1, 3, 1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    start = 1'b1;
    base_addr = 8'd0;
    len = 9'd4;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    start = 1'b0;
    @(negedge sys_clk);
    chk("midrst_ctl", {rd_en, dout_valid, dout_last, busy, done}, 0);
    chk("midrst_data", {addr, dout, first_err}, 0);
    chk("midrst_err", err_cnt, 0);
    @(posedge sys_clk);
    #1;
    sweep(0, 4, 1'b1, 0, 1'b0);

    sweep(40, 60, 1'b1, 0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      int nc;
      nc = $urandom_range(0, 5);
      for (int j = 0; j < nc; j++) ram[$urandom_range(0, 255)] = 8'($urandom);
      sweep($urandom_range(0, 255), $urandom_range(1, 256), 1'($urandom_range(0, 1)), 2, 1'b0);
      fill_identity();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
